// File: rtl/prince_inv_sbox_ts.sv
// prince_inv_sbox_ts -- two-share, time-sharing-masked PRINCE inverse S-box.
//
// Stage 1 re-shares every share-1 monomial with fresh randomness and delays
// share 2. Stage 2 folds in the delayed share 2, completes the degree-2/3
// terms and registers both output shares. Valid/ready handshake on both
// sides, one nibble per cycle when the output is drained.
//
// Build option: define INV_SBOX_DUAL_EN to add the decrypt port, which
// selects the inverse (1) or forward (0) S-box per nibble.
module prince_inv_sbox_ts (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_share1,
    input  logic [3:0]  in_share2,
    input  logic [13:0] rand_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_share1,
    output logic [3:0]  out_share2
`ifdef INV_SBOX_DUAL_EN
    ,
    input  logic        decrypt
`endif
);

    // Algebraic normal form of a 4-bit S-box, one 16-bit coefficient vector
    // per output bit (output bit k at [16*k +: 16]). Coefficient index is the
    // monomial mask with bit3=x, bit2=y, bit1=z, bit0=w.
    function automatic logic [63:0] anf_of(input logic [63:0] tbl);
        logic [15:0] a;
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int m = 0; m < 16; m++) a[m] = tbl[m*4 + k];
            for (int i = 0; i < 4; i++)
                for (int m = 0; m < 16; m++)
                    if (((m >> i) & 1) == 1) a[m] = a[m] ^ a[m ^ (1 << i)];
            r[16*k +: 16] = a;
        end
        return r;
    endfunction

    // Value of monomial m evaluated on nibble v.
    function automatic logic mono(input logic [3:0] m, input logic [3:0] v);
        return (v & m) == m;
    endfunction

    // Truth tables, entry i at [4*i +: 4].
    localparam logic [63:0] SINV_TBL = 64'h1CE5046A98DF237B;
    localparam logic [63:0] SFWD_TBL = 64'h4D5E087619CA23FB;
    localparam logic [63:0] ANF_INV  = anf_of(SINV_TBL);
    localparam logic [63:0] ANF_FWD  = anf_of(SFWD_TBL);

    // Monomial mask consuming rand_in[i], stored at [4*i +: 4]:
    // x,y,z,w, xy,xz,xw,yz,yw,zw, xyz,xyw,xzw,yzw.
    localparam logic [55:0] MONO_ORDER = 56'h7BDE3569AC1248;

    logic        s1_valid_q, s1_valid_d;
    logic [14:1] s0a_q, s0a_d;   // share-1 monomials, first re-share (randomness)
    logic [14:1] s0b_q, s0b_d;   // share-1 monomials, second re-share
    logic [3:0]  sh2_q, sh2_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out1_q, out1_d, out2_q, out2_d;
    logic        adv1, adv2;
    logic [14:1] t1, t2;
    logic [3:0]  ma, mb, mc;

`ifdef INV_SBOX_DUAL_EN
    logic        dec_q, dec_d;
`else
    logic        dec_q;
    assign dec_q = 1'b1;
`endif

    assign adv2       = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready   = ~s1_valid_q | adv2;
    assign adv1       = in_valid & in_ready;
    assign out_valid  = out_valid_q;
    assign out_share1 = out1_q;
    assign out_share2 = out2_q;

    // Stage 1: re-share every share-1 monomial, delay share 2.
    always_comb begin
        s0a_d      = s0a_q;
        s0b_d      = s0b_q;
        sh2_d      = sh2_q;
        s1_valid_d = s1_valid_q;
        if (adv1) begin
            for (int i = 0; i < 14; i++) begin
                s0a_d[MONO_ORDER[4*i +: 4]] = rand_in[i];
                s0b_d[MONO_ORDER[4*i +: 4]] = mono(MONO_ORDER[4*i +: 4], in_share1) ^ rand_in[i];
            end
            sh2_d      = in_share2;
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: complete every monomial per share by folding in delayed share 2.
    always_comb begin
        t1 = '0;
        t2 = '0;
        ma = '0;
        mb = '0;
        mc = '0;
        for (int pa = 0; pa < 4; pa++) begin
            ma     = 4'(1 << pa);
            t1[ma] = s0a_q[ma];
            t2[ma] = s0b_q[ma] ^ sh2_q[pa];
        end
        for (int pa = 1; pa < 4; pa++) begin
            for (int pb = 0; pb < pa; pb++) begin
                ma = 4'(1 << pa);
                mb = 4'(1 << pb);
                t1[ma|mb] = s0a_q[ma|mb] ^ (s0a_q[ma] & sh2_q[pb]) ^ (s0a_q[mb] & sh2_q[pa]);
                t2[ma|mb] = s0b_q[ma|mb] ^ (s0b_q[ma] & sh2_q[pb]) ^ (s0b_q[mb] & sh2_q[pa])
                          ^ (sh2_q[pa] & sh2_q[pb]);
            end
        end
        // The full share-2 degree-2 term already carries a2&b2, so its product
        // with c2 supplies the a2&b2&c2 contribution of the cubic term.
        for (int pa = 2; pa < 4; pa++) begin
            for (int pb = 1; pb < pa; pb++) begin
                for (int pc = 0; pc < pb; pc++) begin
                    ma = 4'(1 << pa);
                    mb = 4'(1 << pb);
                    mc = 4'(1 << pc);
                    t1[ma|mb|mc] = (t1[ma|mb] & sh2_q[pc]) ^ s0a_q[ma|mb|mc]
                                 ^ (s0a_q[ma|mc] & sh2_q[pb]) ^ (s0a_q[mb|mc] & sh2_q[pa])
                                 ^ (s0a_q[mc] & sh2_q[pa] & sh2_q[pb]);
                    t2[ma|mb|mc] = (t2[ma|mb] & sh2_q[pc]) ^ s0b_q[ma|mb|mc]
                                 ^ (s0b_q[ma|mc] & sh2_q[pb]) ^ (s0b_q[mb|mc] & sh2_q[pa])
                                 ^ (s0b_q[mc] & sh2_q[pa] & sh2_q[pb]);
                end
            end
        end
    end

    // Stage 2 output: sum the ANF terms per share; constant term goes to share 1.
    always_comb begin
        out_valid_d = out_valid_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        if (adv2) begin
            out_valid_d = 1'b1;
            for (int k = 0; k < 4; k++) begin
                out1_d[k] = dec_q ? ANF_INV[16*k] : ANF_FWD[16*k];
                out2_d[k] = 1'b0;
                for (int m = 1; m < 15; m++) begin
                    out1_d[k] = out1_d[k] ^ ((dec_q ? ANF_INV[16*k + m] : ANF_FWD[16*k + m]) & t1[m]);
                    out2_d[k] = out2_d[k] ^ ((dec_q ? ANF_INV[16*k + m] : ANF_FWD[16*k + m]) & t2[m]);
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef INV_SBOX_DUAL_EN
    // Direction select travels with the nibble through stage 1.
    always_comb begin
        dec_d = adv1 ? decrypt : dec_q;
    end
`endif

    // Pipeline registers; reset clears control and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s0a_q       <= '0;
            s0b_q       <= '0;
            sh2_q       <= '0;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
`ifdef INV_SBOX_DUAL_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s0a_q       <= s0a_d;
            s0b_q       <= s0b_d;
            sh2_q       <= sh2_d;
            out_valid_q <= out_valid_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
`ifdef INV_SBOX_DUAL_EN
            dec_q       <= dec_d;
`endif
        end
    end

endmodule

// File: tb/tb_prince_inv_sbox_ts.sv
// Self-checking bench for prince_inv_sbox_ts: directed and randomized
// nibbles with random masks and randomness, checked against a table-based
// model of the S-box and a queue model of the two-slot pipeline.
module tb_prince_inv_sbox_ts;

    localparam logic [3:0] SINV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                         4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
    localparam logic [3:0] SFWD [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_share1;
    logic [3:0]  in_share2;
    logic [13:0] rand_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_share1;
    logic [3:0]  out_share2;
`ifdef INV_SBOX_DUAL_EN
    logic        decrypt_r;
`endif

    always #5 clk = ~clk;

    prince_inv_sbox_ts dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_share1  (in_share1),
        .in_share2  (in_share2),
        .rand_in    (rand_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_share1 (out_share1),
        .out_share2 (out_share2)
`ifdef INV_SBOX_DUAL_EN
        ,
        .decrypt    (decrypt_r)
`endif
    );

    typedef struct {
        logic [3:0] val;
        int         acc;
    } item_t;

    item_t      q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       stalled_prev = 1'b0;
    logic [3:0] held1 = '0;
    logic [3:0] held2 = '0;

    function automatic logic [3:0] ref_out(input logic [3:0] v, input logic d);
        return d ? SINV[v] : SFWD[v];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, update model at the edge.
    // The model: an accepted nibble spends at least one cycle in stage 1, the
    // output slot holds one nibble, and nibbles leave in order.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [13:0] r, input logic ordy, input logic d);
        logic  eov, s1occ, eir;
        item_t it;
        in_valid  = v;
        in_share1 = a;
        in_share2 = b;
        rand_in   = r;
        out_ready = ordy;
`ifdef INV_SBOX_DUAL_EN
        decrypt_r = d;
`endif
        @(negedge clk);
        eov   = (q.size() > 0) && (q[0].acc < cyc);
        s1occ = (q.size() == 2) || ((q.size() == 1) && !eov);
        eir   = !s1occ || !eov || ordy;
        chk("out_valid", {3'b0, out_valid}, {3'b0, eov});
        chk("in_ready", {3'b0, in_ready}, {3'b0, eir});
        if (eov) chk("share_xor", out_share1 ^ out_share2, q[0].val);
        if (eov && stalled_prev) begin
            chk("hold_share1", out_share1, held1);
            chk("hold_share2", out_share2, held2);
        end
        stalled_prev = eov && !ordy;
        held1 = out_share1;
        held2 = out_share2;
        @(posedge clk);
        cyc++;
        if (eov && ordy) void'(q.pop_front());
        if (v && eir) begin
            it.val = ref_out(a ^ b, d);
            it.acc = cyc;
            q.push_back(it);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 14'h0, ordy, 1'b1);
    endtask

    initial begin
        logic [3:0] m;
        rst = 1'b1;
        in_valid = 1'b0;
        in_share1 = '0;
        in_share2 = '0;
        rand_in = '0;
        out_ready = 1'b0;
`ifdef INV_SBOX_DUAL_EN
        decrypt_r = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("rst_out_share1", out_share1, 4'h0);
        chk("rst_out_share2", out_share2, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero input, zero randomness: result B two cycles later.
        step(1'b1, 4'h0, 4'h0, 14'h0, 1'b1, 1'b1);
        idle(3, 1'b1);

        // All share pairs back to back with random randomness.
        for (int i = 0; i < 256; i++)
            step(1'b1, 4'(i >> 4), 4'(i), 14'($urandom), 1'b1, 1'b1);
        idle(3, 1'b1);

        // Nibbles 0..F under random masks, back to back.
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom);
            step(1'b1, 4'(i) ^ m, m, 14'($urandom), 1'b1, 1'b1);
        end
        idle(3, 1'b1);

        // Backpressure: three offers with output blocked, hold, then drain.
        step(1'b1, 4'h3, 4'h0, 14'($urandom), 1'b0, 1'b1);
        step(1'b1, 4'h5, 4'hA, 14'($urandom), 1'b0, 1'b1);
        step(1'b1, 4'h9, 4'h1, 14'($urandom), 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 14'($urandom),
                 ($urandom_range(0, 3) != 0), 1'b1);
        idle(3, 1'b1);

        // Reset with both stages occupied: everything discarded at once.
        step(1'b1, 4'h6, 4'h2, 14'($urandom), 1'b0, 1'b1);
        step(1'b1, 4'h7, 4'h3, 14'($urandom), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("midrst_out_share1", out_share1, 4'h0);
        chk("midrst_out_share2", out_share2, 4'h0);
        q.delete();
        stalled_prev = 1'b0;
        #2;
        rst = 1'b0;
        idle(2, 1'b1);
        step(1'b1, 4'h5, 4'hA, 14'($urandom), 1'b1, 1'b1);
        idle(3, 1'b1);

`ifdef INV_SBOX_DUAL_EN
        // Direction follows each nibble.
        step(1'b1, 4'h0, 4'h0, 14'($urandom), 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'h0, 14'($urandom), 1'b1, 1'b1);
        step(1'b1, 4'h1, 4'h0, 14'($urandom), 1'b1, 1'b0);
        step(1'b1, 4'h1, 4'h0, 14'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 100; i++)
            step(1'b1, 4'($urandom), 4'($urandom), 14'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        idle(3, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
